// File: rtl/snn_step_scheduler.sv
// Timestep scheduler for one spiking-neuron layer: frame pacing,
// per-window spike collection, saturating counts and argmax readout.
module snn_step_scheduler #(
    parameter int NUM_IN     = 961,
    parameter int NUM_NEURON = 10,
    parameter int NUM_STEPS  = 20,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    output logic                          busy_o,
    input  logic                          frame_valid_i,
    output logic                          frame_ready_o,
    input  logic [NUM_IN-1:0]             frame_i,
    output logic [NUM_IN-1:0]             nrn_frame_o,
    output logic                          nrn_rst_o,
    input  logic                          nrn_next_stage_i,
    input  logic [NUM_NEURON-1:0]         nrn_spike_i,
    output logic                          out_valid_o,
    output logic [NUM_NEURON-1:0]         out_spikes_o,
    output logic                          underflow_o,
    output logic                          done_o,
    output logic [$clog2(NUM_NEURON)-1:0] winner_o
);

    localparam int IDX_W = $clog2(NUM_NEURON);
    localparam int BW    = $clog2(NUM_STEPS + 1);

    localparam logic [BW-1:0]        STEPS   = BW'(NUM_STEPS);
    localparam logic [BW-1:0]        LAST    = BW'(NUM_STEPS - 1);
    localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(NUM_NEURON - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PRIME = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] SCAN  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]            state;
    logic [BW-1:0]         b;
    logic [BW-1:0]         taken;
    logic [NUM_IN-1:0]     pend;
    logic                  pend_full;
    logic [NUM_NEURON-1:0] acc;
    logic [NUM_NEURON-1:0] win_spk;
    logic [CNT_WIDTH-1:0]  cnt [NUM_NEURON];
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      best_idx;
    logic [CNT_WIDTH-1:0]  best_val;
    logic                  xfer;
    logic                  boundary;
    logic                  take;
    logic                  report;

    assign busy_o    = (state != IDLE);
    assign nrn_rst_o = (state != RUN);

    always_comb begin
        frame_ready_o = 1'b0;
        unique case (state)
            PRIME:   frame_ready_o = 1'b1;
            RUN:     frame_ready_o = !pend_full && (taken < STEPS);
            default: frame_ready_o = 1'b0;
        endcase
    end

    assign xfer     = frame_valid_i && frame_ready_o;
    assign boundary = (state == RUN) && nrn_next_stage_i;
    assign report   = boundary && (b != '0);
    assign win_spk  = acc | nrn_spike_i;
    assign take     = (cnt[idx] > best_val);

    // Frame pacing, window accumulation and per-window reporting
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            b            <= '0;
            taken        <= '0;
            pend         <= '0;
            pend_full    <= 1'b0;
            nrn_frame_o  <= '0;
            underflow_o  <= 1'b0;
            acc          <= '0;
            out_valid_o  <= 1'b0;
            out_spikes_o <= '0;
        end else begin
            out_valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state       <= PRIME;
                        underflow_o <= 1'b0;
                        pend_full   <= 1'b0;
                        acc         <= '0;
                    end
                end
                PRIME: begin
                    if (xfer) begin
                        nrn_frame_o <= frame_i;
                        b           <= '0;
                        taken       <= BW'(1);
                        acc         <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        if (report) begin
                            out_valid_o  <= 1'b1;
                            out_spikes_o <= win_spk;
                        end
                        acc <= '0;
                        if (b < LAST) begin
                            nrn_frame_o <= pend_full ? pend : '0;
                            if (!pend_full) begin
                                underflow_o <= 1'b1;
                            end
                            pend_full <= 1'b0;
                        end else if (b == LAST) begin
                            nrn_frame_o <= '0;
                        end
                        if (b == STEPS) begin
                            state <= SCAN;
                        end else begin
                            b <= b + 1'b1;
                        end
                    end else begin
                        acc <= win_spk;
                    end
                    // A frame landing on a boundary cycle survives as pending
                    if (xfer) begin
                        pend      <= frame_i;
                        pend_full <= 1'b1;
                        taken     <= taken + 1'b1;
                    end
                end
                SCAN: begin
                    if (idx == IDX_MAX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_NEURON; i++) begin
                cnt[i] <= '0;
            end
        end else if ((state == IDLE) && start_i) begin
            for (int i = 0; i < NUM_NEURON; i++) begin
                cnt[i] <= '0;
            end
        end else if (report) begin
            for (int i = 0; i < NUM_NEURON; i++) begin
                if (win_spk[i] && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Sequential argmax; strict compare keeps the lowest index on ties
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx      <= '0;
            best_idx <= '0;
            best_val <= '0;
            done_o   <= 1'b0;
            winner_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (state == SCAN) begin
                if (take) begin
                    best_val <= cnt[idx];
                    best_idx <= idx;
                end
                idx <= idx + 1'b1;
                if (idx == IDX_MAX) begin
                    done_o   <= 1'b1;
                    winner_o <= take ? idx : best_idx;
                end
            end else begin
                idx      <= '0;
                best_idx <= '0;
                best_val <= '0;
            end
        end
    end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Bench for snn_step_scheduler: stub neuron array, queue-based model,
// per-cycle compare plus literal per-image expectations.
module tb_snn_step_scheduler;

    localparam int NI = 8;
    localparam int NN = 4;
    localparam int NS = 5;
    localparam int CW = 2;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          frame_valid = 1'b0;
    logic          frame_ready;
    logic [NI-1:0] frame_data = '0;
    logic [NI-1:0] nrn_frame;
    logic          nrn_rst;
    logic          nrn_next_stage;
    logic [NN-1:0] nrn_spike;
    logic          out_valid;
    logic [NN-1:0] out_spikes;
    logic          underflow;
    logic          done;
    logic [1:0]    winner;

    always #5 clk = ~clk;

    snn_step_scheduler #(
        .NUM_IN(NI), .NUM_NEURON(NN), .NUM_STEPS(NS), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy),
        .frame_valid_i(frame_valid), .frame_ready_o(frame_ready),
        .frame_i(frame_data), .nrn_frame_o(nrn_frame),
        .nrn_rst_o(nrn_rst), .nrn_next_stage_i(nrn_next_stage),
        .nrn_spike_i(nrn_spike), .out_valid_o(out_valid),
        .out_spikes_o(out_spikes), .underflow_o(underflow),
        .done_o(done), .winner_o(winner)
    );

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Stub neurons: 32-cycle windows, one spike burst per window from pat
    logic [4:0]    tcnt;
    int            win;
    logic [NN-1:0] pat [0:NS];

    always @(posedge clk) begin
        if (nrn_rst) begin
            tcnt <= '0;
            win  <= 0;
        end else begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == 5'd31) win <= win + 1;
        end
    end

    assign nrn_next_stage = !nrn_rst && (tcnt == 5'd31);
    assign nrn_spike = (!nrn_rst && tcnt == 5'd10) ? pat[(win > NS) ? NS : win] : '0;

    // Behavioural model
    int            phase;
    int            mb;
    int            macc_n;
    int            mcnt [NN];
    int            scan_left;
    logic [NI-1:0] q [$];
    logic [NI-1:0] m_frame;
    logic [NN-1:0] m_acc;
    logic [NN-1:0] e_spk;
    bit            e_ov;
    bit            e_done;
    bit            m_under;
    int            e_win;
    bit            hs;

    function automatic bit exp_ready();
        return (phase == 1) || (phase == 2 && q.size() == 0 && macc_n < NS);
    endfunction

    function automatic int argmax();
        int best = -1;
        int bi = 0;
        for (int i = 0; i < NN; i++) begin
            int v = (mcnt[i] > SAT) ? SAT : mcnt[i];
            if (v > best) begin
                best = v;
                bi = i;
            end
        end
        return bi;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0; mb = 0; macc_n = 0; scan_left = 0;
            q.delete();
            m_frame = '0; m_acc = '0; e_spk = '0;
            e_ov = 0; e_done = 0; m_under = 0; e_win = 0;
            for (int i = 0; i < NN; i++) mcnt[i] = 0;
        end else begin
            hs = frame_valid && exp_ready();
            e_ov = 0;
            e_done = 0;
            case (phase)
                0: if (start) begin
                    phase = 1;
                    m_under = 0;
                    q.delete();
                    for (int i = 0; i < NN; i++) mcnt[i] = 0;
                end
                1: if (hs) begin
                    m_frame = frame_data;
                    macc_n = 1; mb = 0; m_acc = '0;
                    phase = 2;
                end
                2: begin
                    if (nrn_next_stage) begin
                        if (mb >= 1) begin
                            e_ov = 1;
                            e_spk = m_acc | nrn_spike;
                            for (int i = 0; i < NN; i++) mcnt[i] += e_spk[i];
                        end
                        m_acc = '0;
                        if (mb < NS - 1) begin
                            if (q.size() > 0) m_frame = q.pop_front();
                            else begin
                                m_frame = '0;
                                m_under = 1;
                            end
                        end else if (mb == NS - 1) m_frame = '0;
                        if (mb == NS) begin
                            phase = 3;
                            scan_left = NN;
                        end else mb++;
                    end else m_acc |= nrn_spike;
                    if (hs) begin
                        q.push_back(frame_data);
                        macc_n++;
                    end
                end
                3: begin
                    scan_left--;
                    if (scan_left == 0) begin
                        phase = 4;
                        e_done = 1;
                        e_win = argmax();
                    end
                end
                default: phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, phase != 0);
            chk("nrn_rst", nrn_rst, phase != 2);
            chk("frame_ready", frame_ready, exp_ready());
            chk("nrn_frame", nrn_frame, m_frame);
            chk("underflow", underflow, m_under);
            chk("out_valid", out_valid, e_ov);
            chk("out_spikes", out_spikes, e_spk);
            chk("done", done, e_done);
            chk("winner", winner, e_win);
        end
    end

    // Event monitor
    int cyc = 0, bnd = 0, reports = 0, xfers = 0, dones = 0;
    int last_bnd_cyc = 0, done_cyc = 0;

    always @(posedge clk) cyc++;
    always @(posedge clk) if (rst_n && frame_valid && frame_ready) xfers++;
    always @(negedge clk) begin
        if (nrn_next_stage === 1'b1) begin
            bnd++;
            last_bnd_cyc = cyc;
        end
        if (out_valid === 1'b1) reports++;
        if (done === 1'b1) begin
            dones++;
            done_cyc = cyc;
        end
    end

    function automatic logic [NI-1:0] frame_val(input int k);
        return NI'((k + 1) * 8'h11);
    endfunction

    task automatic set_pat(input logic [NN-1:0] p0, input logic [NN-1:0] p1,
                           input logic [NN-1:0] p2, input logic [NN-1:0] p3,
                           input logic [NN-1:0] p4, input logic [NN-1:0] p5);
        pat[0] = p0; pat[1] = p1; pat[2] = p2;
        pat[3] = p3; pat[4] = p4; pat[5] = p5;
    endtask

    task automatic clear_events();
        bnd = 0; reports = 0; xfers = 0; dones = 0;
    endtask

    task automatic run_image(input bit starve, input int exp_win, input bit exp_under);
        int g;
        clear_events();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (starve && k == 1) begin
                frame_valid = 1'b0;
                g = 0;
                while (bnd < 1 && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                chk("boundary0_seen", bnd >= 1, 1);
                @(negedge clk);
                chk("starve_nrn_frame", nrn_frame, 0);
                chk("starve_underflow", underflow, 1);
            end
            frame_valid = 1'b1;
            frame_data = frame_val(k);
            // start while busy must be ignored
            start = (k == 2);
            g = 0;
            while (!frame_ready && g < 400) begin
                @(negedge clk);
                g++;
            end
            chk("ready_wait", g < 400, 1);
            @(negedge clk);
            start = 1'b0;
        end
        frame_valid = 1'b0;
        g = 0;
        while (dones == 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", dones, 1);
        chk("report_count", reports, NS);
        chk("transfers", xfers, NS);
        chk("done_latency", done_cyc - last_bnd_cyc, NN + 1);
        chk("winner_lit", winner, exp_win);
        chk("underflow_lit", underflow, exp_under);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, frame_ready, 0);
        chk({tag, "_nrn_frame"}, nrn_frame, 0);
        chk({tag, "_nrn_rst"}, nrn_rst, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_spikes"}, out_spikes, 0);
        chk({tag, "_underflow"}, underflow, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_winner"}, winner, 0);
    endtask

    initial begin
        int g;
        set_pat(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        #1 rst_n = 1'b0;
        #1 check_reset_values("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1;

        // window 0 garbage must never be reported
        set_pat(4'b1111, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100);
        run_image(0, 2, 0);

        set_pat(4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010);
        run_image(1, 1, 1);

        set_pat(4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b0001, 4'b0000);
        run_image(0, 1, 0);

        // reset mid-image after boundary 0
        set_pat(4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000);
        clear_events();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        frame_valid = 1'b1;
        frame_data = frame_val(0);
        g = 0;
        while (bnd < 1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("rst_boundary0_seen", bnd >= 1, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("midrst_no_done", dones, 0);

        set_pat(4'b1111, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100);
        run_image(0, 2, 0);

        // neuron 0 saturates at 3 and ties neuron 1; wrap would pick 1
        set_pat(4'b1111, 4'b0111, 4'b0111, 4'b0011, 4'b0001, 4'b0001);
        run_image(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
